// File: rtl/alu_srcb_seq_ctrl.sv
// Multicycle control FSM for a small MIPS-like datapath. Sequences the ALU
// operand-B source mux and the PC/IR/memory/register-file strobes for
// add/sub/and, addi, lw, sw, beq, bne and j. Memory-touching states (fetch,
// load, store) are held for MEM_LAT cycles by a 4-bit wait counter.
module alu_srcb_seq_ctrl #(
  parameter int MEM_LAT = 1  // memory access cycles, legal 1..15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [1:0] alusrcb_sel,
  output logic       alusrca_sel,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_ADDR    = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_WB_R    = 4'd7,
    S_WB_I    = 4'd8,
    S_WB_MEM  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_e;

  // All controls travel together so reset can blank them in one place.
  typedef struct packed {
    logic [1:0] srcb;
    logic       srca;
    logic [2:0] op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic [3:0] state;
  } ctrl_t;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMX4 = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

  state_e     r_state;
  logic [3:0] r_wait;
  logic       r_bne;      // branch flavour captured in DECODE
  state_e     w_next;
  ctrl_t      w_ctrl;
  ctrl_t      w_out;
  logic       w_counting;
  logic       w_wait_done;

  assign w_counting  = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                       (r_state == S_MEM_WR);
  assign w_wait_done = (r_wait == LAST_WAIT);

  // State register, memory wait counter and captured branch polarity.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state <= S_FETCH;
      r_wait  <= 4'd0;
      r_bne   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_counting && !w_wait_done) r_wait <= r_wait + 4'd1;
      else                            r_wait <= 4'd0;
      if (r_state == S_DECODE) r_bne <= (opcode == OP_BNE);
    end
  end

  // Next-state logic and per-state control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first; any path that
    // skipped an assignment would otherwise infer a latch.
    w_next       = S_FETCH;
    w_ctrl       = '0;
    w_ctrl.state = r_state;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_rd = 1'b1;
        w_ctrl.srcb   = SRCB_FOUR;
        w_ctrl.op     = ALU_ADD;
        if (w_wait_done) begin
          w_ctrl.ir_write = 1'b1;
          w_ctrl.pc_write = 1'b1;
          w_next          = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        w_ctrl.srcb = SRCB_IMMX4;  // branch target into ALUOut
        w_ctrl.op   = ALU_ADD;
        case (opcode)
          OP_RTYPE:      w_next = (funct == FN_ADD || funct == FN_SUB ||
                                   funct == FN_AND) ? S_EXEC_R : S_ILLEGAL;
          OP_ADDI:       w_next = S_EXEC_I;
          OP_LW, OP_SW:  w_next = S_ADDR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_J:          w_next = S_JUMP;
          default:       w_next = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        w_ctrl.srca = 1'b1;
        w_ctrl.srcb = SRCB_B;
        case (funct)
          FN_ADD:  w_ctrl.op = ALU_ADD;
          FN_SUB:  w_ctrl.op = ALU_SUB;
          FN_AND:  w_ctrl.op = ALU_AND;
          default: w_ctrl.op = 3'b000;
        endcase
        w_next = S_WB_R;
      end
      S_WB_R: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
        w_next           = S_FETCH;
      end
      S_EXEC_I: begin
        w_ctrl.srca = 1'b1;
        w_ctrl.srcb = SRCB_IMM;
        w_ctrl.op   = ALU_ADD;
        w_next      = S_WB_I;
      end
      S_WB_I: begin
        w_ctrl.reg_write = 1'b1;
        w_next           = S_FETCH;
      end
      S_ADDR: begin
        w_ctrl.srca = 1'b1;
        w_ctrl.srcb = SRCB_IMM;
        w_ctrl.op   = ALU_ADD;
        w_next      = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        w_ctrl.mem_rd = 1'b1;
        w_next        = w_wait_done ? S_WB_MEM : S_MEM_RD;
      end
      S_MEM_WR: begin
        w_ctrl.mem_wr = 1'b1;
        w_next        = w_wait_done ? S_FETCH : S_MEM_WR;
      end
      S_WB_MEM: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_next            = S_FETCH;
      end
      S_BRANCH: begin
        w_ctrl.srca     = 1'b1;
        w_ctrl.srcb     = SRCB_B;
        w_ctrl.op       = ALU_SUB;
        w_ctrl.pc_src   = 2'd1;
        w_ctrl.pc_write = r_bne ? !zero : zero;
        w_next          = S_FETCH;
      end
      S_JUMP: begin
        w_ctrl.pc_src   = 2'd2;
        w_ctrl.pc_write = 1'b1;
        w_next          = S_FETCH;
      end
      S_ILLEGAL: begin
        w_ctrl.illegal = 1'b1;
        w_next         = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // NOTE: reset is synchronous for the state, but the strobes are blanked
  // combinationally so nothing fires while reset is held in any state.
  assign w_out = reset ? '0 : w_ctrl;

  assign alusrcb_sel = w_out.srcb;
  assign alusrca_sel = w_out.srca;
  assign alu_op      = w_out.op;
  assign pc_src      = w_out.pc_src;
  assign pc_write    = w_out.pc_write;
  assign ir_write    = w_out.ir_write;
  assign mem_rd      = w_out.mem_rd;
  assign mem_wr      = w_out.mem_wr;
  assign reg_write   = w_out.reg_write;
  assign reg_dst     = w_out.reg_dst;
  assign mem_to_reg  = w_out.mem_to_reg;
  assign illegal_op  = w_out.illegal;
  assign state_out   = w_out.state;

endmodule
